// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the MAC tx_axis port.
// A grant is held from the first beat to tlast; the output goes through a skid buffer.
module eth_tx_frame_arbiter #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          grant_valid,
  output logic [SEL_WIDTH-1:0]          grant_index
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  grant_index_q, grant_index_d;
  logic [SEL_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic                  grant_valid_q, grant_valid_d;
  logic                  ready_int_q, ready_int_d;

  logic                  tvalid_g;
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  last_p0, user_p0;

  logic                  out_vld_p1, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_p1;
  logic                  out_last_p1, out_user_p1;
  logic                  tmp_vld_p1, tmp_vld_d;
  logic [DATA_WIDTH-1:0] tmp_data_p1;
  logic                  tmp_last_p1, tmp_user_p1;
  logic                  load_out_in, load_out_tmp, load_tmp_in;

  // First requester found searching upward from the port after last.
  function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [S_COUNT-1:0] req,
                                                   input logic [SEL_WIDTH-1:0] last);
    logic [SEL_WIDTH-1:0] pick;
    int                   idx;
    pick = last;
    for (int k = S_COUNT; k >= 1; k--) begin
      idx = (int'(last) + k) % S_COUNT;
      for (int j = 0; j < S_COUNT; j++) begin
        if (j == idx && req[j]) pick = SEL_WIDTH'(j);
      end
    end
    return pick;
  endfunction

  // Stage p0: granted port selection and input handshake
  always_comb begin
    tvalid_g      = 1'b0;
    data_p0       = '0;
    last_p0       = 1'b0;
    user_p0       = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index_q == SEL_WIDTH'(i)) begin
        tvalid_g = s_axis_tvalid[i];
        data_p0  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        last_p0  = s_axis_tlast[i];
        user_p0  = s_axis_tuser[i];
      end
      s_axis_tready[i] = grant_valid_q & ready_int_q & (grant_index_q == SEL_WIDTH'(i));
    end
  end

  assign vld_p0 = grant_valid_q & ready_int_q & tvalid_g;

  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    grant_valid_d = grant_valid_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          grant_index_d = rr_pick(s_axis_tvalid, last_grant_q);
          grant_valid_d = 1'b1;
          state_d       = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vld_p0 && last_p0) begin
          last_grant_d  = grant_index_q;
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready looks one cycle ahead so that m_axis_tready never reaches s_axis_tready combinationally.
  assign ready_int_d = m_axis_tready | (~tmp_vld_p1 & (~out_vld_p1 | ~vld_p0));

  always_comb begin
    out_vld_d    = out_vld_p1;
    tmp_vld_d    = tmp_vld_p1;
    load_out_in  = 1'b0;
    load_out_tmp = 1'b0;
    load_tmp_in  = 1'b0;
    if (ready_int_q) begin
      if (m_axis_tready || !out_vld_p1) begin
        out_vld_d   = vld_p0;
        load_out_in = 1'b1;
      end else begin
        tmp_vld_d   = vld_p0;
        load_tmp_in = 1'b1;
      end
    end else if (m_axis_tready) begin
      out_vld_d    = tmp_vld_p1;
      tmp_vld_d    = 1'b0;
      load_out_tmp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_index_q <= '0;
      grant_valid_q <= 1'b0;
      last_grant_q  <= SEL_WIDTH'(S_COUNT - 1);
      ready_int_q   <= 1'b0;
      out_vld_p1    <= 1'b0;
      tmp_vld_p1    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
      grant_valid_q <= grant_valid_d;
      last_grant_q  <= last_grant_d;
      ready_int_q   <= ready_int_d;
      out_vld_p1    <= out_vld_d;
      tmp_vld_p1    <= tmp_vld_d;
    end
  end

  // Stage p1: output register and skid temp register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_p1 <= '0;
      out_last_p1 <= 1'b0;
      out_user_p1 <= 1'b0;
    end else if (load_out_in) begin
      out_data_p1 <= data_p0;
      out_last_p1 <= last_p0;
      out_user_p1 <= user_p0;
    end else if (load_out_tmp) begin
      out_data_p1 <= tmp_data_p1;
      out_last_p1 <= tmp_last_p1;
      out_user_p1 <= tmp_user_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_tmp_in) begin
      tmp_data_p1 <= data_p0;
      tmp_last_p1 <= last_p0;
      tmp_user_p1 <= user_p0;
    end
  end

  assign m_axis_tdata  = out_data_p1;
  assign m_axis_tvalid = out_vld_p1;
  assign m_axis_tlast  = out_last_p1;
  assign m_axis_tuser  = out_user_p1;
  assign grant_valid   = grant_valid_q;
  assign grant_index   = grant_index_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: arbitration table plus frame-level sequences.
module tb_eth_tx_frame_arbiter;
  localparam int S_COUNT    = 2;
  localparam int DATA_WIDTH = 8;
  localparam int SEL_WIDTH  = 1;

  if (SEL_WIDTH != $clog2(S_COUNT) || S_COUNT < 2) begin : g_cfg_chk
    $error("bad configuration: SEL_WIDTH %0d S_COUNT %0d", SEL_WIDTH, S_COUNT);
  end

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] dat [2];
  logic       vld [2];
  logic       lst [2];
  logic       usr [2];

  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_COUNT-1:0] s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser, grant_valid;
  logic [SEL_WIDTH-1:0] grant_index;

  assign s_axis_tdata  = {dat[1], dat[0]};
  assign s_axis_tvalid = {vld[1], vld[0]};
  assign s_axis_tlast  = {lst[1], lst[0]};
  assign s_axis_tuser  = {usr[1], usr[0]};

  eth_tx_frame_arbiter #(.S_COUNT(S_COUNT), .DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; logic user; int cyc; } obeat_t;
  typedef struct { int port; logic last; int cyc; } ibeat_t;
  typedef struct { logic [1:0] mask; int exp_port; logic [7:0] exp_data; } vec_t;

  obeat_t out_q[$];
  ibeat_t in_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic stall_prev = 1'b0;
  logic [10:0] held = '0;
  logic p1_busy = 1'b0;
  int p0_rdy_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev)
        chk("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, held);
      if (m_axis_tvalid && m_axis_tready)
        out_q.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser, cyc});
      if ((s_axis_tvalid & s_axis_tready) != 0) begin
        chk("tready_onehot", $countones(s_axis_tvalid & s_axis_tready), 1);
        if (s_axis_tready[1] && s_axis_tvalid[1]) in_q.push_back('{1, s_axis_tlast[1], cyc});
        else in_q.push_back('{0, s_axis_tlast[0], cyc});
      end
      if (p1_busy && s_axis_tready[0]) p0_rdy_bad <= p0_rdy_bad + 1;
      stall_prev <= m_axis_tvalid & ~m_axis_tready;
      held <= {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input logic [1:0] mask);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((s_axis_tready & mask) != 0) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: mask %0b never got tready", mask);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int p, input int len, input logic [7:0] base,
                            input int user_beat, input int gap_at, input int gap_len);
    for (int b = 0; b < len; b++) begin
      if (b == gap_at) begin
        vld[p] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      dat[p] = base + 8'(b);
      lst[p] = (b == len - 1);
      usr[p] = (b == user_beat);
      vld[p] = 1'b1;
      wait_accept(2'(1 << p));
    end
    vld[p] = 1'b0;
    lst[p] = 1'b0;
    usr[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_q.delete();
    out_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    int   t0;
    logic pat [6];
    vecs[0] = '{2'b11, 0, 8'h10};
    vecs[1] = '{2'b11, 1, 8'h81};
    vecs[2] = '{2'b10, 1, 8'h82};
    vecs[3] = '{2'b01, 0, 8'h13};
    vecs[4] = '{2'b01, 0, 8'h14};
    vecs[5] = '{2'b11, 1, 8'h85};
    vecs[6] = '{2'b10, 1, 8'h86};
    vecs[7] = '{2'b11, 0, 8'h17};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int p = 0; p < 2; p++) begin
      dat[p] = '0; vld[p] = 1'b0; lst[p] = 1'b0; usr[p] = 1'b0;
    end
    m_axis_tready = 1'b1;
    rst = 1'b1;
    idle(3);

    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tuser", m_axis_tuser, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_index", grant_index, 0);
    rst = 1'b0;
    idle(1);

    // Round-robin table: one-beat frames, requests given by mask.
    for (int i = 0; i < 8; i++) begin
      in_q.delete();
      out_q.delete();
      dat[0] = 8'h10 + 8'(i);
      dat[1] = 8'h80 + 8'(i);
      lst[0] = 1'b1;
      lst[1] = 1'b1;
      vld[0] = vecs[i].mask[0];
      vld[1] = vecs[i].mask[1];
      wait_accept(vecs[i].mask);
      vld[0] = 1'b0;
      vld[1] = 1'b0;
      idle(4);
      chk("vec_in_count", in_q.size(), 1);
      if (in_q.size() > 0) chk("vec_port", in_q[0].port, vecs[i].exp_port);
      chk("vec_out_count", out_q.size(), 1);
      if (out_q.size() > 0) begin
        chk("vec_data", out_q[0].data, vecs[i].exp_data);
        chk("vec_last", out_q[0].last, 1);
        chk("vec_user", out_q[0].user, 0);
      end
    end
    lst[0] = 1'b0;
    lst[1] = 1'b0;

    // 60-byte frame from port 0.
    idle(2);
    in_q.delete();
    out_q.delete();
    t0 = cyc;
    send_frame(0, 60, 8'h00, -1, -1, 0);
    idle(4);
    chk("f60_out_count", out_q.size(), 60);
    chk("f60_in_count", in_q.size(), 60);
    if (out_q.size() == 60) begin
      chk("f60_latency", out_q[0].cyc - t0, 2);
      for (int k = 0; k < 60; k++) begin
        chk("f60_data", out_q[k].data, k);
        chk("f60_last", out_q[k].last, (k == 59) ? 1 : 0);
        chk("f60_user", out_q[k].user, 0);
      end
    end
    foreach (in_q[k]) chk("f60_port", in_q[k].port, 0);

    // Both ports contend, 4 frames of 3 beats each.
    do_reset();
    fork
      for (int f = 0; f < 4; f++) send_frame(0, 3, 8'(f * 16), -1, -1, 0);
      for (int f = 0; f < 4; f++) send_frame(1, 3, 8'h80 + 8'(f * 16), -1, -1, 0);
    join
    idle(4);
    chk("rr_in_count", in_q.size(), 24);
    chk("rr_out_count", out_q.size(), 24);
    if (in_q.size() == 24) begin
      for (int n = 0; n < 8; n++) chk("rr_frame_port", in_q[3 * n].port, n % 2);
      for (int n = 0; n < 7; n++) chk("rr_dead_cycle", in_q[3 * n + 3].cyc - in_q[3 * n + 2].cyc, 2);
    end
    if (out_q.size() == 24) begin
      for (int n = 0; n < 8; n++) begin
        for (int b = 0; b < 3; b++) begin
          chk("rr_data", out_q[3 * n + b].data, ((n % 2) * 8'h80) + (n / 2) * 16 + b);
          chk("rr_last", out_q[3 * n + b].last, (b == 2) ? 1 : 0);
        end
      end
    end

    // Back-pressure on the output during a 16-byte frame.
    in_q.delete();
    out_q.delete();
    fork
      send_frame(0, 16, 8'h20, -1, -1, 0);
      begin
        for (int k = 0; k < 80; k++) begin
          m_axis_tready = pat[k % 6];
          @(posedge clk);
          #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    idle(4);
    chk("bp_out_count", out_q.size(), 16);
    if (out_q.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk("bp_data", out_q[k].data, 8'h20 + k);
        chk("bp_last", out_q[k].last, (k == 15) ? 1 : 0);
      end
    end

    // Port 1 pauses 20 cycles mid-frame while port 0 waits.
    in_q.delete();
    out_q.delete();
    p0_rdy_bad = 0;
    fork
      begin
        p1_busy = 1'b1;
        send_frame(1, 8, 8'h50, -1, 3, 20);
        p1_busy = 1'b0;
      end
      send_frame(0, 2, 8'h60, -1, -1, 0);
    join
    idle(4);
    chk("lock_p0_ready", p0_rdy_bad, 0);
    chk("lock_in_count", in_q.size(), 10);
    chk("lock_out_count", out_q.size(), 10);
    if (in_q.size() == 10) begin
      chk("lock_first_port", in_q[0].port, 1);
      chk("lock_p1_end_port", in_q[7].port, 1);
      chk("lock_next_port", in_q[8].port, 0);
    end
    if (out_q.size() == 10) begin
      for (int k = 0; k < 8; k++) chk("lock_p1_data", out_q[k].data, 8'h50 + k);
      chk("lock_p0_data0", out_q[8].data, 8'h60);
      chk("lock_p0_data1", out_q[9].data, 8'h61);
    end

    // Reset in the middle of a 10-beat frame.
    for (int b = 0; b < 5; b++) begin
      dat[0] = 8'h70 + 8'(b);
      lst[0] = 1'b0;
      vld[0] = 1'b1;
      wait_accept(2'b01);
    end
    vld[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_q.delete();
    out_q.delete();
    chk("mrst_m_tvalid", m_axis_tvalid, 0);
    chk("mrst_grant_valid", grant_valid, 0);
    chk("mrst_s_tready", s_axis_tready, 0);
    fork
      send_frame(0, 1, 8'h90, -1, -1, 0);
      send_frame(1, 1, 8'hA0, -1, -1, 0);
    join
    idle(4);
    chk("mrst_in_count", in_q.size(), 2);
    chk("mrst_out_count", out_q.size(), 2);
    if (in_q.size() == 2) chk("mrst_first_port", in_q[0].port, 0);
    if (out_q.size() == 2) begin
      chk("mrst_data0", out_q[0].data, 8'h90);
      chk("mrst_data1", out_q[1].data, 8'hA0);
    end

    // tuser set only on the tlast beat.
    in_q.delete();
    out_q.delete();
    send_frame(1, 4, 8'hC0, 3, -1, 0);
    idle(4);
    chk("user_out_count", out_q.size(), 4);
    if (out_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("user_flag", out_q[k].user, (k == 3) ? 1 : 0);
        chk("user_last", out_q[k].last, (k == 3) ? 1 : 0);
        chk("user_data", out_q[k].data, 8'hC0 + k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares the single AXI-stream TX input of the 1G MAC between S_COUNT requesters, for example a CPU packet path and a hardware UDP/ARP engine.
- Sits in the MAC tx_clk domain, directly in front of the MAC tx_axis port.
- A grant is held from the first beat of a frame to its tlast, so frames are never interleaved.
- Output is registered through a skid buffer, giving full throughput with no combinational path from m_axis_tready to any s_axis_tready.

Parameters:
- S_COUNT, 2: number of requesters, minimum 2.
- DATA_WIDTH, 8: tdata width per port; 8 matches the MAC.
- SEL_WIDTH, 1: width of grant_index; must equal ceil(log2(S_COUNT)).

Ports:
- clk  input  1  tx clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset; driven from tx_rst.
- s_axis_tdata  input  S_COUNT*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  input  S_COUNT  per-port valid.
- s_axis_tready  output  S_COUNT  per-port ready.
- s_axis_tlast  input  S_COUNT  per-port end of frame.
- s_axis_tuser  input  S_COUNT  per-port bad-frame flag.
- m_axis_tdata  output  DATA_WIDTH  to MAC tx_axis_tdata.
- m_axis_tvalid  output  1  to MAC tx_axis_tvalid.
- m_axis_tready  input  1  from MAC tx_axis_tready.
- m_axis_tlast  output  1  to MAC tx_axis_tlast.
- m_axis_tuser  output  1  to MAC tx_axis_tuser.
- grant_valid  output  1  a frame is currently granted.
- grant_index  output  SEL_WIDTH  index of the granted port; meaningful only while grant_valid=1.

Behaviour:
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata/tlast/tuser=0.
  - s_axis_tready=all 0.
  - grant_valid=0, grant_index=0.
  - last_grant=S_COUNT-1, so port 0 wins first.
  - skid temp register empty.
- State machine, IDLE / ACTIVE:
  - IDLE: all s_axis_tready=0.
    - If any s_axis_tvalid=1, choose the first set bit searching upward from (last_grant+1) mod S_COUNT, wrapping.
    - Register that choice into grant_index, set grant_valid=1, go to ACTIVE.
    - Arbitration decision to first possible acceptance: 1 cycle.
  - ACTIVE: s_axis_tready[grant_index] = internal ready; all other ports' ready=0.
    - On an accepted beat (tvalid & tready on the granted port) with tlast=1: last_grant <= grant_index, grant_valid <= 0, go to IDLE.
    - Result: exactly one dead input cycle between consecutive frames. This is acceptable because the MAC inserts the IFG.
- Frame lock:
  - A granted requester that deasserts tvalid mid-frame keeps the grant indefinitely; there is no timeout.
  - Other requesters stall.
- Skid buffer (output register + one temp register):
  - Internal ready (registered) = m_axis_tready | (~temp_valid & (~m_axis_tvalid | ~granted tvalid)).
  - Accepted beat goes to the output register if the output register is empty or m_axis_tready=1; otherwise it goes to the temp register.
  - Temp register drains to the output on the next m_axis_tready=1.
  - Latency from input acceptance to m_axis_tvalid: 1 cycle.
  - Sustained throughput: 1 beat/cycle while m_axis_tready=1.
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tlast/tuser hold stable.
  - No beat is dropped or duplicated.
- Data passthrough: tdata, tlast and tuser pass unmodified from the granted port; tuser is propagated on every beat, including tlast.
- Fairness: with all ports continuously requesting, grants rotate 0,1,...,S_COUNT-1,0,..., one frame each.
- Simultaneous events: a new tvalid arriving on the same cycle the current frame's tlast is accepted is not granted until the following IDLE cycle.
- Reset mid-frame:
  - The output register and temp register are discarded and the state returns to IDLE with reset values.
  - The partial frame is truncated; the MAC shares rst and is reset coherently.
- SEL_WIDTH mismatch with S_COUNT is a configuration error; the bench checks it with an elaboration assertion.

Test Plan:
- Single port 0 sends a 60-byte frame 0x00..0x3B with m_axis_tready=1 -> m_axis carries an identical 60 beats starting 2 cycles after the first s_axis_tvalid; tlast on beat 60; grant_index=0 throughout.
- Ports 0 and 1 both assert tvalid in the same cycle, 3-beat frames each, repeated 4 times -> output frame order 0,1,0,1,0,1,0,1; exactly one idle input cycle between frames.
- m_axis_tready toggled 1,0,0,1,0,1... during a 16-byte frame -> all 16 bytes appear in order, none lost or duplicated; tdata held stable on every cycle with tready=0.
- Port 1 mid-frame drops tvalid for 20 cycles while port 0 requests -> port 0 s_axis_tready stays 0; port 1 frame resumes and completes; port 0 is granted next.
- rst asserted for 1 cycle at beat 5 of a 10-beat frame -> next cycle m_axis_tvalid=0, grant_valid=0, s_axis_tready=0; the following request is arbitrated starting from port 0.
- Frame with tuser=1 on its tlast beat -> m_axis_tuser=1 on exactly that output beat, 0 on all others.
